// File: rtl/pll_pkg.sv
// Shared constants, state encoding and helpers for the DPLL loop controller.
package pll_pkg;

  // Datapath width of the DAC word and of the gain outputs.
  localparam int DAC_W = 20;
  localparam logic [DAC_W-1:0] DAC_MAX = {DAC_W{1'b1}};

  // Default loop constants; the top exposes them as overridable parameters.
  localparam logic [DAC_W-1:0] DEF_P_ACQ = DAC_W'(2000);
  localparam logic [DAC_W-1:0] DEF_P_TRK = DAC_W'(500);
  localparam int DEF_WIN_LEN        = 256;
  localparam int DEF_LOCK_TOGGLES   = 64;
  localparam int DEF_LOCK_WINS      = 4;
  localparam int DEF_UNLOCK_TOGGLES = 16;
  localparam int DEF_SAT_CYCLES     = 4096;
  localparam int DEF_RESTART_CYCLES = 16;

  // State codes as seen on the debug port.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_FILT = 3'd1;
  localparam logic [2:0] ST_ACQUIRE  = 3'd2;
  localparam logic [2:0] ST_TRACK    = 3'd3;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RST_FILT = ST_RST_FILT,
    ACQUIRE  = ST_ACQUIRE,
    TRACK    = ST_TRACK
  } pll_state_e;

  // True in the states where the filter runs and the monitors are live.
  function automatic logic is_loop_state(input pll_state_e s);
    return (s == ACQUIRE) || (s == TRACK);
  endfunction

endpackage

// File: rtl/pll_toggle_window.sv
// Counts phase-detector toggles over fixed-length observation windows.
// o_win_toggles already includes a toggle seen on the window-end cycle.
module pll_toggle_window
  import pll_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clr,
  input  logic                           i_x,
  output logic                           o_win_end,
  output logic [$clog2(WIN_LEN+1)-1:0]   o_win_toggles
);

  localparam int WCNT_W = $clog2(WIN_LEN);
  localparam int TOG_W  = $clog2(WIN_LEN + 1);

  logic              r_x_d;
  logic [WCNT_W-1:0] r_win_cnt;
  logic [TOG_W-1:0]  r_tog_cnt;
  logic              w_toggle;
  logic [TOG_W-1:0]  w_tog_inc;

  assign w_toggle  = i_x ^ r_x_d;
  assign o_win_end = (r_win_cnt == WCNT_W'(WIN_LEN - 1));
  assign w_tog_inc = (w_toggle && (r_tog_cnt < TOG_W'(WIN_LEN))) ? r_tog_cnt + TOG_W'(1)
                                                                  : r_tog_cnt;
  assign o_win_toggles = w_tog_inc;

  // Delay x for edge detection; advance window and toggle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_d     <= 1'b0;
      r_win_cnt <= '0;
      r_tog_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, like real flops.
      r_x_d <= i_x;
      if (i_clr || o_win_end) begin
        r_win_cnt <= '0;
        r_tog_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + WCNT_W'(1);
        r_tog_cnt <= w_tog_inc;
      end
    end
  end

endmodule

// File: rtl/pll_loop_controller.sv
// DPLL loop sequencer: filter reset, acquisition, lock detection from PD
// toggle density, tracking gain, and restart on prolonged DAC saturation.
module pll_loop_controller
  import pll_pkg::*;
#(
  parameter logic [DAC_W-1:0] P_ACQ          = DEF_P_ACQ,
  parameter logic [DAC_W-1:0] P_TRK          = DEF_P_TRK,
  parameter int               WIN_LEN        = DEF_WIN_LEN,
  parameter int               LOCK_TOGGLES   = DEF_LOCK_TOGGLES,
  parameter int               LOCK_WINS      = DEF_LOCK_WINS,
  parameter int               UNLOCK_TOGGLES = DEF_UNLOCK_TOGGLES,
  parameter int               SAT_CYCLES     = DEF_SAT_CYCLES,
  parameter int               RESTART_CYCLES = DEF_RESTART_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic [DAC_W-1:0] dac,
  output logic [DAC_W-1:0] p_gain,
  output logic             filt_rst,
  output logic             locked,
  output logic [2:0]       state,
  output logic [7:0]       restart_cnt
);

  localparam int TOG_W  = $clog2(WIN_LEN + 1);
  localparam int SAT_W  = $clog2(SAT_CYCLES + 1);
  localparam int GOOD_W = $clog2(LOCK_WINS + 1);
  localparam int RST_W  = $clog2(RESTART_CYCLES + 1);

  pll_state_e        r_state;
  pll_state_e        w_next;
  logic [DAC_W-1:0]  r_p_gain;
  logic              r_filt_rst;
  logic              r_locked;
  logic [7:0]        r_restart_cnt;
  logic [SAT_W-1:0]  r_sat_cnt;
  logic [GOOD_W-1:0] r_good_wins;
  logic [RST_W-1:0]  r_rst_cnt;

  logic              w_win_end;
  logic [TOG_W-1:0]  w_win_toggles;
  logic              w_win_clr;
  logic              w_rail;
  logic [SAT_W-1:0]  w_sat_next;
  logic              w_sat_trip;
  logic [GOOD_W-1:0] w_good_next;

  // Window counters restart whenever the loop enters ACQUIRE or TRACK and
  // stay parked while the loop is not running.
  assign w_win_clr = !is_loop_state(w_next) || (w_next != r_state);

  pll_toggle_window #(
    .WIN_LEN (WIN_LEN)
  ) u_win (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_win_clr),
    .i_x           (x),
    .o_win_end     (w_win_end),
    .o_win_toggles (w_win_toggles)
  );

  // Next-state decision: disable beats saturation restart beats window verdict.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    w_rail      = (dac == '0) || (dac == DAC_MAX);
    w_sat_next  = (is_loop_state(r_state) && w_rail) ? r_sat_cnt + SAT_W'(1) : '0;
    w_sat_trip  = (w_sat_next == SAT_W'(SAT_CYCLES));
    w_good_next = r_good_wins;
    if (w_win_end) begin
      w_good_next = (w_win_toggles >= TOG_W'(LOCK_TOGGLES)) ? r_good_wins + GOOD_W'(1) : '0;
    end

    w_next = r_state;
    if (!en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = RST_FILT;
        RST_FILT: begin
          if (r_rst_cnt == RST_W'(RESTART_CYCLES - 1)) w_next = ACQUIRE;
        end
        ACQUIRE: begin
          if (w_sat_trip)                             w_next = RST_FILT;
          else if (w_good_next == GOOD_W'(LOCK_WINS)) w_next = TRACK;
        end
        TRACK: begin
          if (w_sat_trip) w_next = RST_FILT;
          else if (w_win_end && (w_win_toggles < TOG_W'(UNLOCK_TOGGLES))) w_next = ACQUIRE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // State register, outputs decoded from the next state, and loop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_p_gain      <= P_ACQ;
      r_filt_rst    <= 1'b0;
      r_locked      <= 1'b0;
      r_restart_cnt <= '0;
      r_sat_cnt     <= '0;
      r_good_wins   <= '0;
      r_rst_cnt     <= '0;
    end else begin
      r_state    <= w_next;
      r_p_gain   <= (w_next == TRACK) ? P_TRK : P_ACQ;
      r_filt_rst <= is_loop_state(w_next);
      r_locked   <= (w_next == TRACK);

      // Filter-reset hold timer counts only while staying in RST_FILT.
      r_rst_cnt <= ((r_state == RST_FILT) && (w_next == RST_FILT)) ? r_rst_cnt + RST_W'(1) : '0;

      // Rail-run length survives ACQUIRE<->TRACK but not a trip or leaving the loop.
      r_sat_cnt <= (w_sat_trip || !is_loop_state(w_next)) ? '0 : w_sat_next;

      // Good-window run only matters while acquisition continues.
      r_good_wins <= ((r_state == ACQUIRE) && (w_next == ACQUIRE)) ? w_good_next : '0;

      if (en && w_sat_trip && (r_restart_cnt != 8'hFF)) begin
        r_restart_cnt <= r_restart_cnt + 8'd1;
      end
    end
  end

  assign p_gain      = r_p_gain;
  assign filt_rst    = r_filt_rst;
  assign locked      = r_locked;
  assign state       = r_state;
  assign restart_cnt = r_restart_cnt;

endmodule

// File: tb/tb_pll_loop_controller.sv
// Self-checking bench for pll_loop_controller: directed vector table,
// hand-written corner sequences, then random stimulus against a model.
module tb_pll_loop_controller;

  localparam int              W        = 20;
  localparam logic [W-1:0]    RAIL_HI  = 20'hFFFFF;
  localparam logic [W-1:0]    MID      = 20'h5A5A5;
  localparam int              G_ACQ    = 2000;
  localparam int              G_TRK    = 500;
  localparam int              WIN      = 256;
  localparam int              LOCK_T   = 64;
  localparam int              LOCK_W   = 4;
  localparam int              UNLOCK_T = 16;
  localparam int              SAT      = 4096;
  localparam int              RESTART  = 16;
  localparam int              X_HOLD   = 0;
  localparam int              X_TOG    = 1;
  localparam int              X_ONE    = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         x   = 1'b0;
  logic [W-1:0] dac = MID;
  logic [W-1:0] p_gain;
  logic         filt_rst;
  logic         locked;
  logic [2:0]   state;
  logic [7:0]   restart_cnt;

  int n_vec = 0;
  int n_bad = 0;

  pll_loop_controller dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .dac         (dac),
    .p_gain      (p_gain),
    .filt_rst    (filt_rst),
    .locked      (locked),
    .state       (state),
    .restart_cnt (restart_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    int           x_mode;
    logic [W-1:0] dac;
    int           n;
    int           e_state;
    int           e_filt;
    int           e_lock;
    int           e_gain;
    int           e_rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en_i, input int xm, input logic [W-1:0] d, input int n,
                              input int es, input int ef, input int el, input int eg, input int er);
    vec_t v;
    v.en = en_i; v.x_mode = xm; v.dac = d; v.n = n;
    v.e_state = es; v.e_filt = ef; v.e_lock = el; v.e_gain = eg; v.e_rc = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int es, input int ef, input int el,
                           input int eg, input int er);
    check({tag, ".state"},       32'(state),       32'(es));
    check({tag, ".filt_rst"},    32'(filt_rst),    32'(ef));
    check({tag, ".locked"},      32'(locked),      32'(el));
    check({tag, ".p_gain"},      32'(p_gain),      32'(eg));
    check({tag, ".restart_cnt"}, 32'(restart_cnt), 32'(er));
  endtask

  // One clock of stimulus; returns at the following falling edge.
  task automatic drive_cycle(input logic en_i, input int xm, input logic [W-1:0] d);
    en  = en_i;
    dac = d;
    if (xm == X_TOG) x = ~x;
    else if (xm == X_ONE) x = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks time spent in the current state; window position is that age
  // modulo the window length.
  int   m_state, m_age, m_tog, m_good, m_rail, m_rc;
  logic m_px;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_tog = 0; m_good = 0; m_rail = 0; m_rc = 0; m_px = 1'b0;
  endtask

  task automatic model_step(input logic en_i, input logic x_i, input logic [W-1:0] d);
    int nxt;
    bit tgl, wend, trip, in_loop;
    tgl  = (x_i != m_px);
    m_px = x_i;
    in_loop = (m_state == 2) || (m_state == 3);
    wend = 1'b0;
    trip = 1'b0;
    if (in_loop) begin
      if (tgl) m_tog++;
      wend   = ((m_age % WIN) == WIN - 1);
      m_rail = ((d == 0) || (d == RAIL_HI)) ? m_rail + 1 : 0;
      trip   = (m_rail >= SAT);
    end else begin
      m_rail = 0;
    end
    nxt = m_state;
    if (!en_i) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (m_age + 1 >= RESTART) nxt = 2;
    end else if (trip) begin
      nxt = 1;
      if (m_rc < 255) m_rc++;
    end else if (wend) begin
      if (m_state == 2) begin
        m_good = (m_tog >= LOCK_T) ? m_good + 1 : 0;
        if (m_good >= LOCK_W) nxt = 3;
      end else if (m_tog < UNLOCK_T) begin
        nxt = 2;
      end
    end
    if (wend) m_tog = 0;
    if (nxt != m_state) begin
      m_age = 0;
      m_tog = 0;
      if (nxt == 2) m_good = 0;
    end else begin
      m_age++;
    end
    m_state = nxt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seg_len, tog_pct, dmode, cyc;
    logic en_v;
    logic [W-1:0] dac_v;

    // -------- reset state --------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 0, 0, G_ACQ, 0);
    rst = 1'b1;

    // -------- directed vector table --------
    // Bring-up: RST_FILT held for exactly RESTART cycles, then ACQUIRE.
    vecs.push_back(mk(1, X_HOLD, MID, 1,    1, 0, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_HOLD, MID, 15,   1, 0, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_HOLD, MID, 1,    2, 1, 0, G_ACQ, 0));
    // Continuous toggling: lock after four full windows.
    vecs.push_back(mk(1, X_TOG,  MID, 1023, 2, 1, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_TOG,  MID, 1,    3, 1, 1, G_TRK, 0));
    // Silent window in TRACK drops back to ACQUIRE at its end.
    vecs.push_back(mk(1, X_ONE,  MID, 255,  3, 1, 1, G_TRK, 0));
    vecs.push_back(mk(1, X_ONE,  MID, 1,    2, 1, 0, G_ACQ, 0));
    // 3 good + 1 bad + 4 good: bad window must clear the run.
    vecs.push_back(mk(1, X_TOG,  MID, 768,  2, 1, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_HOLD, MID, 256,  2, 1, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_TOG,  MID, 768,  2, 1, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_TOG,  MID, 255,  2, 1, 0, G_ACQ, 0));
    vecs.push_back(mk(1, X_TOG,  MID, 1,    3, 1, 1, G_TRK, 0));
    // High rail for SAT cycles in TRACK trips a restart.
    vecs.push_back(mk(1, X_TOG,  RAIL_HI, 4095, 3, 1, 1, G_TRK, 0));
    vecs.push_back(mk(1, X_TOG,  RAIL_HI, 1,    1, 0, 0, G_ACQ, 1));
    vecs.push_back(mk(1, X_HOLD, '0,  15,   1, 0, 0, G_ACQ, 1));
    vecs.push_back(mk(1, X_HOLD, '0,  1,    2, 1, 0, G_ACQ, 1));
    // Low rail one cycle short of the limit, then released: no restart.
    vecs.push_back(mk(1, X_HOLD, '0,  4095, 2, 1, 0, G_ACQ, 1));
    vecs.push_back(mk(1, X_HOLD, 20'd5, 1,  2, 1, 0, G_ACQ, 1));
    // Disable on the very cycle saturation would trip: IDLE, count unchanged.
    vecs.push_back(mk(1, X_HOLD, RAIL_HI, 4095, 2, 1, 0, G_ACQ, 1));
    vecs.push_back(mk(0, X_HOLD, RAIL_HI, 1,    0, 0, 0, G_ACQ, 1));
    // Disable in the middle of RST_FILT aborts to IDLE.
    vecs.push_back(mk(1, X_HOLD, MID, 1,    1, 0, 0, G_ACQ, 1));
    vecs.push_back(mk(0, X_HOLD, MID, 1,    0, 0, 0, G_ACQ, 1));
    // Re-enable all the way to TRACK.
    vecs.push_back(mk(1, X_HOLD, MID, 17,   2, 1, 0, G_ACQ, 1));
    vecs.push_back(mk(1, X_TOG,  MID, 1024, 3, 1, 1, G_TRK, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) drive_cycle(vecs[i].en, vecs[i].x_mode, vecs[i].dac);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_filt, vecs[i].e_lock,
                vecs[i].e_gain, vecs[i].e_rc);
    end

    // -------- async reset in TRACK, checked before any clock edge --------
    #2 rst = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, G_ACQ, 0);
    en = 1'b0;
    x  = 1'b0;
    dac = MID;
    @(posedge clk);
    @(negedge clk);
    check_all("rst_held", 0, 0, 0, G_ACQ, 0);
    rst = 1'b1;

    // -------- randomized stimulus against the model --------
    model_reset();
    cyc = 0;
    while (cyc < 30000) begin
      seg_len = $urandom_range(600, 40);
      en_v    = ($urandom_range(99, 0) >= 3);
      if (!en_v) seg_len = $urandom_range(20, 1);
      case ($urandom_range(4, 0))
        0:       tog_pct = 95;
        1:       tog_pct = 30;
        2:       tog_pct = 25;
        3:       tog_pct = 5;
        default: tog_pct = 0;
      endcase
      dmode = $urandom_range(99, 0);
      if (dmode < 10) seg_len = $urandom_range(4100, 4090);
      for (int c = 0; c < seg_len; c++) begin
        if (dmode < 6)       dac_v = RAIL_HI;
        else if (dmode < 10) dac_v = '0;
        else if (dmode < 14) dac_v = ($urandom_range(1, 0) == 1) ? RAIL_HI : W'($urandom_range(20, 1));
        else                 dac_v = W'($urandom_range(32'hFFFFE, 1));
        en  = en_v;
        dac = dac_v;
        if ($urandom_range(99, 0) < tog_pct) x = ~x;
        model_step(en, x, dac);
        @(posedge clk);
        @(negedge clk);
        check_all($sformatf("rnd%0d", cyc), m_state, (m_state == 2 || m_state == 3) ? 1 : 0,
                  (m_state == 3) ? 1 : 0, (m_state == 3) ? G_TRK : G_ACQ, m_rc);
        cyc++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
